// File: rtl/loader_pkg.sv
// Shared types and constants for the instruction memory loader.
// Depth of the instruction memory the loader targets.
package loader_pkg;

  localparam int LDR_DEPTH = 2048;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_COMMIT = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/inst_mem_loader.sv
// Boot-time instruction memory writer: streams a program into imem
// and holds the pipeline in reset until the last word is committed.
module inst_mem_loader
  import loader_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 11,
  parameter int DEPTH  = LDR_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              START,
  input  logic [ADDR_W:0]   LEN,
  input  logic              S_VALID,
  input  logic [WIDTH-1:0]  S_DATA,
  output logic              S_READY,
  output logic              WR_EN,
  output logic [ADDR_W-1:0] WR_ADR,
  output logic [WIDTH-1:0]  WR_DATA,
  output logic              CPU_RST,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [WIDTH-1:0]  CHECKSUM
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W:0]   len_q;
  logic              accept;
  logic              last;
  logic              legal;

  assign S_READY = (state == ST_LOAD);
  assign BUSY    = (state == ST_LOAD) || (state == ST_COMMIT);
  assign DONE    = (state == ST_DONE);
  // Pipeline runs only once the final write has left the output register.
  assign CPU_RST = (state != ST_DONE);

  assign accept = S_VALID & S_READY;
  assign last   = (count == len_q - 1'b1);
  assign legal  = (LEN != '0) && (LEN <= DEPTH_L);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      count    <= '0;
      len_q    <= '0;
      WR_EN    <= 1'b0;
      WR_ADR   <= '0;
      WR_DATA  <= '0;
      ERR      <= 1'b0;
      CHECKSUM <= '0;
    end else begin
      WR_EN <= accept;
      if (accept) begin
        WR_ADR   <= count[ADDR_W-1:0];
        WR_DATA  <= S_DATA;
        count    <= count + 1'b1;
        CHECKSUM <= CHECKSUM ^ S_DATA;
      end
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (START) begin
            if (legal) begin
              len_q    <= LEN;
              count    <= '0;
              CHECKSUM <= '0;
              ERR      <= 1'b0;
              state    <= ST_LOAD;
            end else begin
              ERR <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (accept && last)
            state <= ST_COMMIT;
        end
        ST_COMMIT: state <= ST_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Self-checking bench for inst_mem_loader: vector table, directed
// corner sequences and randomized loads checked against a write log.
module tb_inst_mem_loader;
  import loader_pkg::*;

  localparam int W  = 32;
  localparam int AW = 11;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          START = 1'b0;
  logic [AW:0]   LEN = '0;
  logic          S_VALID = 1'b0;
  logic [W-1:0]  S_DATA = '0;
  logic          S_READY;
  logic          WR_EN;
  logic [AW-1:0] WR_ADR;
  logic [W-1:0]  WR_DATA;
  logic          CPU_RST;
  logic          BUSY;
  logic          DONE;
  logic          ERR;
  logic [W-1:0]  CHECKSUM;

  inst_mem_loader #(
    .WIDTH(W),
    .ADDR_W(AW),
    .DEPTH(LDR_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .START(START),
    .LEN(LEN),
    .S_VALID(S_VALID),
    .S_DATA(S_DATA),
    .S_READY(S_READY),
    .WR_EN(WR_EN),
    .WR_ADR(WR_ADR),
    .WR_DATA(WR_DATA),
    .CPU_RST(CPU_RST),
    .BUSY(BUSY),
    .DONE(DONE),
    .ERR(ERR),
    .CHECKSUM(CHECKSUM)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [AW+W-1:0] wr_log[$];
  logic [W-1:0]    src[$];
  bit              vpat[$];

  always @(posedge clk)
    if (WR_EN) wr_log.push_back({WR_ADR, WR_DATA});

  typedef struct {
    bit          start;
    logic [AW:0] len;
    bit          valid;
    bit          err;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: every valid word in LOAD is accepted; word i lands at address i.
  task automatic run_load(input int len, input int gap);
    logic [W-1:0] w[$];
    logic [W-1:0] x;
    int           acc;
    int           cyc;
    bit           v;
    x = '0;
    acc = 0;
    cyc = 0;
    wr_log.delete();
    START = 1'b1;
    LEN = len[AW:0];
    step();
    START = 1'b0;
    check("start_busy", BUSY, 1);
    check("start_cpu_rst", CPU_RST, 1);
    check("start_done", DONE, 0);
    check("start_cksum", CHECKSUM, 0);
    check("start_err", ERR, 0);
    while (acc < len && cyc < 4 * len + 64) begin
      if (vpat.size() > 0) v = vpat.pop_front();
      else v = ($urandom_range(99) >= gap);
      S_VALID = v;
      if (src.size() > 0) S_DATA = src.pop_front();
      else S_DATA = $urandom;
      check("ready", S_READY, 1);
      if (v) begin
        w.push_back(S_DATA);
        x ^= S_DATA;
      end
      step();
      cyc++;
      check("wr_en", WR_EN, v);
      if (v) begin
        check("wr_adr", WR_ADR, acc);
        check("wr_data", WR_DATA, w[acc]);
        acc++;
      end
    end
    S_VALID = 1'b0;
    if (acc < len) begin
      check("load_timeout", acc, len);
    end else begin
      check("commit_busy", BUSY, 1);
      check("commit_done", DONE, 0);
      check("commit_cpu_rst", CPU_RST, 1);
      check("commit_ready", S_READY, 0);
      step();
      check("done", DONE, 1);
      check("done_cpu_rst", CPU_RST, 0);
      check("done_busy", BUSY, 0);
      check("done_wr_en", WR_EN, 0);
      check("cksum", CHECKSUM, x);
      check("n_writes", wr_log.size(), len);
      for (int i = 0; i < len && i < wr_log.size(); i++) begin
        check("log_adr", wr_log[i][AW+W-1:W], i);
        check("log_data", wr_log[i][W-1:0], w[i]);
      end
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 12'd5,    1'b1, 1'b0};
    tbl[1] = '{1'b1, 12'd0,    1'b0, 1'b1};
    tbl[2] = '{1'b0, 12'd0,    1'b1, 1'b1};
    tbl[3] = '{1'b1, 12'd2049, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 12'd7,    1'b1, 1'b1};
    tbl[5] = '{1'b1, 12'd4095, 1'b1, 1'b1};

    repeat (3) step();
    rst = 1'b0;
    check("rst_cpu_rst", CPU_RST, 1);
    check("rst_ready", S_READY, 0);
    check("rst_done", DONE, 0);
    check("rst_wr_en", WR_EN, 0);
    check("rst_busy", BUSY, 0);
    check("rst_err", ERR, 0);
    check("rst_cksum", CHECKSUM, 0);
    check("rst_wr_adr", WR_ADR, 0);

    // Idle-state vectors: illegal LEN and stray S_VALID.
    foreach (tbl[i]) begin
      START = tbl[i].start;
      LEN = tbl[i].len;
      S_VALID = tbl[i].valid;
      S_DATA = $urandom;
      step();
      check("tbl_err", ERR, tbl[i].err);
      check("tbl_busy", BUSY, 0);
      check("tbl_ready", S_READY, 0);
      check("tbl_cpu_rst", CPU_RST, 1);
      step();
      check("tbl_wr_en", WR_EN, 0);
    end
    START = 1'b0;
    S_VALID = 1'b0;

    run_load(1, 0);

    src = '{32'h00500093, 32'h00A00113, 32'h002081B3};
    vpat = '{1'b1, 1'b1, 1'b1};
    run_load(3, 0);
    check("basic_cksum", CHECKSUM, 32'h00D08033);

    // Illegal START in DONE keeps the pipeline running.
    START = 1'b1;
    LEN = '0;
    step();
    START = 1'b0;
    check("done_ill_err", ERR, 1);
    check("done_ill_done", DONE, 1);
    check("done_ill_cpu_rst", CPU_RST, 0);
    check("done_ill_cksum", CHECKSUM, 32'h00D08033);

    vpat = '{1'b1, 1'b0, 1'b0, 1'b1};
    run_load(2, 0);

    // Reset in the middle of a load drops the pending write.
    START = 1'b1;
    LEN = 12'd4;
    step();
    START = 1'b0;
    S_VALID = 1'b1;
    S_DATA = 32'hDEADBEEF;
    step();
    S_DATA = 32'h12345678;
    step();
    check("mid_wr_en_pre", WR_EN, 1);
    S_VALID = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_wr_en", WR_EN, 0);
    check("mid_cpu_rst", CPU_RST, 1);
    check("mid_ready", S_READY, 0);
    check("mid_busy", BUSY, 0);
    check("mid_cksum", CHECKSUM, 0);
    step();
    rst = 1'b0;
    step();
    check("mid_idle_busy", BUSY, 0);
    run_load(1, 0);

    for (int k = 0; k < 6; k++)
      run_load($urandom_range(40, 1), 40);

    run_load(LDR_DEPTH, 0);
    if (wr_log.size() > 0)
      check("last_adr", wr_log[wr_log.size()-1][AW+W-1:W], 11'h7FF);
    run_load(1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
